// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and its MMU neighbour.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    // mem_size encodings; 2'd3 falls through to word handling.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // bytemode = {unsigned, lane enables[3:0]}
    localparam logic [4:0] BM_WORD         = 5'b01111;
    localparam int         BM_UNSIGNED_BIT = 4;

    typedef enum logic {
        S_NORMAL    = 1'b0,
        S_DATA_DONE = 1'b1
    } state_t;

    // Device addresses decoded by the MMU; the arbiter treats them like RAM.
    localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
    localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;
    localparam logic [31:0] LED_ADDR       = 32'hBFD0_F000;
    localparam logic [31:0] DPY_ADDR       = 32'hBFD0_F010;

endpackage

// File: rtl/mem_arbiter_bytemode_enc.sv
// Encodes access size/offset/sign into the MMU bytemode and flags misalignment.
// Latency: purely combinational.
// Backpressure: none.
// Ports: size, addr_lo (addr[1:0]), is_unsigned, we -> bytemode[4:0], misaligned.
module mem_arbiter_bytemode_enc
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    input  logic       is_unsigned,
    input  logic       we,
    output logic [4:0] bytemode,
    output logic       misaligned
);

    always_comb begin
        bytemode   = BM_WORD;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                bytemode[3:0]           = 4'b0001 << addr_lo;
                bytemode[BM_UNSIGNED_BIT] = is_unsigned & ~we;
            end
            SZ_HALF: begin
                bytemode[3:0]           = addr_lo[1] ? 4'b1100 : 4'b0011;
                bytemode[BM_UNSIGNED_BIT] = is_unsigned & ~we;
                misaligned              = addr_lo[0];
            end
            // Word (and the reserved code 3): full lanes, never extended.
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port MMU between instruction fetch and load/store; data wins.
// Latency: results registered 1 cycle after issue; a data access costs one stall cycle.
// Backpressure: stall_req freezes the front end while data owns the port; fetch is
// never denied more than one cycle because the cycle after a data access is fetch-only.
// Ports: clk/rst; IF request/result; MEM request/result/addr_err; stall_req; MMU drive.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_addr_err,
    output logic        stall_req,
    output logic        mmu_if_read,
    output logic        mmu_if_write,
    output logic [31:0] mmu_addr,
    output logic [31:0] mmu_input_data,
    output logic [4:0]  mmu_bytemode,
    input  logic [31:0] mmu_output_data
);

    state_t     state, state_nxt;
    logic [4:0] data_bytemode;
    logic       misaligned;
    logic       data_access;

    mem_arbiter_bytemode_enc u_enc (
        .size        (mem_size),
        .addr_lo     (mem_addr[1:0]),
        .is_unsigned (mem_unsigned),
        .we          (mem_we),
        .bytemode    (data_bytemode),
        .misaligned  (misaligned)
    );

    // In S_DATA_DONE the MEM stage still presents the request just served,
    // so it must not be reissued (or flagged) until the pipeline advances.
    assign data_access  = (state == S_NORMAL) & mem_req & ~misaligned & ~rst;
    assign mem_addr_err = (state == S_NORMAL) & mem_req & misaligned;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_NORMAL;
        else     state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = S_NORMAL;
        if (state == S_NORMAL && data_access) state_nxt = S_DATA_DONE;
    end

    // Outputs to the MMU and pipeline
    always_comb begin
        mmu_if_read    = 1'b0;
        mmu_if_write   = 1'b0;
        mmu_addr       = RESET_PC;
        mmu_bytemode   = BM_WORD;
        mmu_input_data = 32'h0;
        stall_req      = 1'b0;
        if (!rst) begin
            if (data_access) begin
                mmu_addr       = mem_addr;
                mmu_if_read    = ~mem_we;
                mmu_if_write   = mem_we;
                mmu_bytemode   = data_bytemode;
                mmu_input_data = mem_we ? mem_wdata : 32'h0;
                stall_req      = 1'b1;
            end else begin
                mmu_addr    = if_addr;
                mmu_if_read = if_req;
            end
        end
    end

    // Capture MMU read data; reset drops any fetch pending from S_DATA_DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata  <= 32'h0;
            mem_rdata <= 32'h0;
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
        end else if (data_access) begin
            mem_rdata <= mem_we ? 32'h0 : mmu_output_data;
            mem_valid <= 1'b1;
            if_valid  <= 1'b0;
        end else if (if_req) begin
            if_rdata  <= mmu_output_data;
            if_valid  <= 1'b1;
            mem_valid <= 1'b0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [1:0]  mem_size = 2'd0;
    logic        mem_unsigned = 1'b0;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_addr_err;
    logic        stall_req;
    logic        mmu_if_read;
    logic        mmu_if_write;
    logic [31:0] mmu_addr;
    logic [31:0] mmu_input_data;
    logic [4:0]  mmu_bytemode;
    logic [31:0] mmu_output_data = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.RESET_PC(32'h8000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_rdata        (if_rdata),
        .if_valid        (if_valid),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_size        (mem_size),
        .mem_unsigned    (mem_unsigned),
        .mem_rdata       (mem_rdata),
        .mem_valid       (mem_valid),
        .mem_addr_err    (mem_addr_err),
        .stall_req       (stall_req),
        .mmu_if_read     (mmu_if_read),
        .mmu_if_write    (mmu_if_write),
        .mmu_addr        (mmu_addr),
        .mmu_input_data  (mmu_input_data),
        .mmu_bytemode    (mmu_bytemode),
        .mmu_output_data (mmu_output_data)
    );

    always #5 clk = ~clk;

    // Reference model: "served" means the previous cycle gave the port to data,
    // so this cycle belongs to fetch regardless of mem_req.
    bit          m_served = 1'b0;
    bit          m_data;
    logic [31:0] m_if_rdata = 32'h0, m_mem_rdata = 32'h0;
    logic        m_if_valid = 1'b0, m_mem_valid = 1'b0;
    logic        e_read, e_write, e_stall, e_err;
    logic [4:0]  e_bm;
    logic [31:0] e_addr, e_in;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    task automatic model_comb();
        int n, en;
        bit mis;
        n      = nbytes(mem_size);
        mis    = (int'(mem_addr[1:0]) % n) != 0;
        m_data = !rst && mem_req && !mis && !m_served;
        en     = ((1 << n) - 1) << mem_addr[1:0];
        e_read  = rst ? 1'b0 : (m_data ? !mem_we : if_req);
        e_write = m_data && mem_we;
        e_stall = m_data;
        e_err   = mem_req && mis && !m_served;
        e_addr  = rst ? 32'h8000_0000 : (m_data ? mem_addr : if_addr);
        e_in    = (m_data && mem_we) ? mem_wdata : 32'h0;
        e_bm    = m_data ? {mem_unsigned && !mem_we && n < 4, en[3:0]} : 5'b01111;
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        model_comb();
        if (rst) begin
            m_if_rdata = 32'h0; m_mem_rdata = 32'h0; m_if_valid = 1'b0; m_mem_valid = 1'b0;
        end else if (m_data) begin
            m_mem_rdata = mem_we ? 32'h0 : mmu_output_data; m_mem_valid = 1'b1; m_if_valid = 1'b0;
        end else if (if_req) begin
            m_if_rdata = mmu_output_data; m_if_valid = 1'b1; m_mem_valid = 1'b0;
        end else begin
            m_if_valid = 1'b0; m_mem_valid = 1'b0;
        end
        m_served = m_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h8000_0100; mem_req = 1'b0;
        tick();
        #1;
        n_tests++;
        if ({mmu_if_read, mmu_if_write, stall_req, mmu_bytemode, mmu_addr} !== {3'b000, 5'b01111, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL reset_comb got rd=%b wr=%b st=%b bm=%b addr=%h want 0 0 0 01111 80000000",
                     mmu_if_read, mmu_if_write, stall_req, mmu_bytemode, mmu_addr);
        end
        tick();
        n_tests++;
        if ({if_valid, mem_valid, if_rdata, mem_rdata} !== 66'h0) begin
            n_fail++;
            $display("FAIL reset_regs got ifv=%b memv=%b ifd=%h memd=%h want all zero",
                     if_valid, mem_valid, if_rdata, mem_rdata);
        end
    endtask

    task automatic test_fetch();
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h8000_0004; mmu_output_data = 32'h2402_0005;
        #1;
        n_tests++;
        if ({mmu_if_read, stall_req, mmu_addr} !== {2'b10, 32'h8000_0004}) begin
            n_fail++;
            $display("FAIL fetch_issue got rd=%b st=%b addr=%h want 1 0 80000004", mmu_if_read, stall_req, mmu_addr);
        end
        tick();
        n_tests++;
        if ({if_valid, if_rdata} !== {1'b1, 32'h2402_0005}) begin
            n_fail++;
            $display("FAIL fetch_data got v=%b d=%h want 1 24020005", if_valid, if_rdata);
        end
    endtask

    task automatic test_lb();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8040_0003; mem_size = 2'd0; mem_unsigned = 1'b0;
        if_addr = 32'h8000_0008; mmu_output_data = 32'hFFFF_FF85;
        #1;
        n_tests++;
        if ({mmu_bytemode, stall_req, mmu_if_read, mmu_addr} !== {5'b01000, 2'b11, 32'h8040_0003}) begin
            n_fail++;
            $display("FAIL lb_issue got bm=%b st=%b rd=%b addr=%h want 01000 1 1 80400003",
                     mmu_bytemode, stall_req, mmu_if_read, mmu_addr);
        end
        tick();
        mmu_output_data = 32'h0000_0013;
        #1;
        n_tests++;
        if ({mem_valid, mem_rdata, stall_req, mmu_addr} !== {1'b1, 32'hFFFF_FF85, 1'b0, 32'h8000_0008}) begin
            n_fail++;
            $display("FAIL lb_result got v=%b d=%h st=%b addr=%h want 1 ffffff85 0 80000008",
                     mem_valid, mem_rdata, stall_req, mmu_addr);
        end
        tick();
        mem_req = 1'b0;
        n_tests++;
        if ({if_valid, if_rdata, mem_valid} !== {1'b1, 32'h0000_0013, 1'b0}) begin
            n_fail++;
            $display("FAIL lb_fetch_after got ifv=%b d=%h memv=%b want 1 00000013 0", if_valid, if_rdata, mem_valid);
        end
    endtask

    task automatic test_sh();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0002; mem_size = 2'd1;
        mem_unsigned = 1'b1; mem_wdata = 32'h1234_ABCD; mmu_output_data = 32'h5555_5555;
        #1;
        n_tests++;
        if ({mmu_if_write, mmu_if_read, mmu_bytemode, mmu_input_data} !== {2'b10, 5'b01100, 32'h1234_ABCD}) begin
            n_fail++;
            $display("FAIL sh_issue got wr=%b rd=%b bm=%b wd=%h want 1 0 01100 1234abcd",
                     mmu_if_write, mmu_if_read, mmu_bytemode, mmu_input_data);
        end
        tick();
        #1;
        n_tests++;
        if ({mem_valid, mem_rdata, mmu_if_write, mmu_input_data} !== {1'b1, 32'h0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL sh_done got v=%b d=%h wr=%b wd=%h want 1 0 0 0",
                     mem_valid, mem_rdata, mmu_if_write, mmu_input_data);
        end
        tick();
        mem_req = 1'b0; mem_we = 1'b0; mem_unsigned = 1'b0;
    endtask

    task automatic test_misaligned();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0006; mem_size = 2'd2;
        if_req = 1'b1; if_addr = 32'h8000_0010; mmu_output_data = 32'hABCD_0001;
        #1;
        n_tests++;
        if ({mem_addr_err, mmu_if_write, stall_req, mmu_if_read, mmu_addr} !== {4'b1001, 32'h8000_0010}) begin
            n_fail++;
            $display("FAIL misaligned got err=%b wr=%b st=%b rd=%b addr=%h want 1 0 0 1 80000010",
                     mem_addr_err, mmu_if_write, stall_req, mmu_if_read, mmu_addr);
        end
        tick();
        mem_req = 1'b0;
        n_tests++;
        if ({mem_valid, if_valid, if_rdata} !== {2'b01, 32'hABCD_0001}) begin
            n_fail++;
            $display("FAIL misaligned_regs got memv=%b ifv=%b d=%h want 0 1 abcd0001", mem_valid, if_valid, if_rdata);
        end
    endtask

    task automatic test_back_to_back();
        if_req = 1'b1; if_addr = 32'h8000_0020; mem_we = 1'b0; mem_size = 2'd2;
        for (int i = 0; i < 3; i++) begin
            mem_req = 1'b1; mem_addr = 32'h8000_1000 + 32'(4 * i); mmu_output_data = 32'hD000_0000 + 32'(i);
            #1;
            n_tests++;
            if ({stall_req, mmu_addr} !== {1'b1, mem_addr}) begin
                n_fail++;
                $display("FAIL b2b_data%0d got st=%b addr=%h want 1 %h", i, stall_req, mmu_addr, mem_addr);
            end
            tick();
            mmu_output_data = 32'hF000_0000 + 32'(i);
            #1;
            n_tests++;
            if ({stall_req, mmu_addr, mem_rdata} !== {1'b0, 32'h8000_0020, 32'hD000_0000 + 32'(i)}) begin
                n_fail++;
                $display("FAIL b2b_fetch%0d got st=%b addr=%h d=%h want 0 80000020 %h",
                         i, stall_req, mmu_addr, mem_rdata, 32'hD000_0000 + 32'(i));
            end
            tick();
        end
        // One more load, then reset during its S_DATA_DONE cycle.
        mem_addr = 32'h8000_2000;
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({if_valid, mem_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_reset got ifv=%b memv=%b want 0 0", if_valid, mem_valid);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_after_reset got st=%b want 1", stall_req);
        end
        tick();
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst             = ($urandom_range(0, 29) == 0);
            if_req          = $urandom_range(0, 3) != 0;
            if_addr         = {$urandom(), 2'b00} >> 0;
            mem_req         = $urandom_range(0, 1);
            mem_we          = $urandom_range(0, 1);
            mem_addr        = $urandom();
            mem_wdata       = $urandom();
            mem_size        = 2'($urandom_range(0, 3));
            mem_unsigned    = $urandom_range(0, 1);
            mmu_output_data = $urandom();
            #1;
            model_comb();
            n_tests++;
            if ({mmu_if_read, mmu_if_write, stall_req, mem_addr_err, mmu_bytemode, mmu_addr, mmu_input_data} !==
                {e_read, e_write, e_stall, e_err, e_bm, e_addr, e_in}) begin
                n_fail++;
                $display("FAIL rand_comb c=%0d got rd=%b wr=%b st=%b err=%b bm=%b a=%h wd=%h want %b %b %b %b %b %h %h",
                         c, mmu_if_read, mmu_if_write, stall_req, mem_addr_err, mmu_bytemode, mmu_addr, mmu_input_data,
                         e_read, e_write, e_stall, e_err, e_bm, e_addr, e_in);
            end
            tick();
            n_tests++;
            if ({if_valid, mem_valid, if_rdata, mem_rdata} !== {m_if_valid, m_mem_valid, m_if_rdata, m_mem_rdata}) begin
                n_fail++;
                $display("FAIL rand_regs c=%0d got ifv=%b memv=%b ifd=%h memd=%h want %b %b %h %h",
                         c, if_valid, mem_valid, if_rdata, mem_rdata, m_if_valid, m_mem_valid, m_if_rdata, m_mem_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_lb();
        test_sh();
        test_misaligned();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
